// File: rtl/btu_pkg.sv
// Shared BTU payload types and the arbiter state encoding.
package btu_pkg;

  localparam int unsigned BTU_DIM_W  = 8;
  localparam int unsigned BTU_MODE_W = 8;
  localparam int unsigned BTU_OP_W   = 32;

  typedef struct packed {
    logic [BTU_DIM_W-1:0]  n;
    logic [BTU_MODE_W-1:0] mode;
    logic [BTU_OP_W-1:0]   operand;
  } btu_input_t;

  typedef struct packed {
    logic [BTU_DIM_W-1:0] num_rows;
    logic [BTU_OP_W-1:0]  result;
  } btu_output_t;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } btu_arb_state_t;

endpackage

// File: rtl/btu_tag_fifo.sv
// Flop-based in-order FIFO holding requester IDs of issued BTU operations.
module btu_tag_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/btu_arbiter.sv
// Round-robin front end sharing one BTU between NUM_REQ requesters; a tag FIFO
// steers each in-order BTU result back to the requester that issued it.
module btu_arbiter
  import btu_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic        [NUM_REQ-1:0]          req_valid,
  output logic        [NUM_REQ-1:0]          req_ready,
  input  btu_input_t  [NUM_REQ-1:0]          req_data,
  output logic                               btu_valid_in,
  input  logic                               btu_ready_in,
  output btu_input_t                         btu_data_in,
  input  logic                               btu_valid_out,
  output logic                               btu_ready_out,
  input  btu_output_t                        btu_data_out,
  output logic        [NUM_REQ-1:0]          rsp_valid,
  input  logic        [NUM_REQ-1:0]          rsp_ready,
  output btu_output_t                        rsp_data,
  output logic        [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                               proto_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  btu_arb_state_t   r_state;
  btu_arb_state_t   w_state_nxt;
  logic [ID_W-1:0]  r_held_id;
  logic [ID_W-1:0]  w_held_id_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_rr_ptr_nxt;
  logic             r_proto_err;
  logic             w_proto_err_nxt;

  logic [ID_W-1:0]  w_grant;
  logic             w_issue;
  logic             w_pop;
  logic [ID_W-1:0]  w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;

  // First asserted request at or after ptr, wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && v[ID_W'(idx)]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  btu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_issue),
    .i_wdata (w_grant),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_held_id   <= '0;
      r_rr_ptr    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_held_id   <= w_held_id_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_held_id_nxt   = r_held_id;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_proto_err_nxt = r_proto_err;
    w_grant         = rr_pick(req_valid, r_rr_ptr);
    btu_valid_in    = 1'b0;
    req_ready       = '0;
    rsp_valid       = '0;
    btu_ready_out   = 1'b0;

    case (r_state)
      ARB: begin
        btu_valid_in = (|req_valid) & ~w_fifo_full;
      end
      HOLD: begin
        // A requester abandoning its held request is flagged and not issued.
        w_grant      = r_held_id;
        btu_valid_in = req_valid[r_held_id];
        if (!req_valid[r_held_id]) begin
          w_proto_err_nxt = 1'b1;
          w_state_nxt     = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase

    btu_data_in = req_data[w_grant];
    w_issue     = btu_valid_in & btu_ready_in;

    if (w_issue) begin
      req_ready[w_grant] = 1'b1;
      w_rr_ptr_nxt       = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
      w_state_nxt        = ARB;
    end else if (btu_valid_in && (r_state == ARB)) begin
      w_state_nxt   = HOLD;
      w_held_id_nxt = w_grant;
    end

    // Results arrive in issue order, so the FIFO head names their owner.
    if (w_fifo_empty) begin
      btu_ready_out = btu_valid_out;
      if (btu_valid_out) w_proto_err_nxt = 1'b1;
    end else begin
      btu_ready_out     = rsp_ready[w_head];
      rsp_valid[w_head] = btu_valid_out;
    end
    w_pop = btu_valid_out & btu_ready_out & ~w_fifo_empty;
  end

  assign rsp_data    = btu_data_out;
  assign outstanding = w_fifo_count;
  assign proto_err   = r_proto_err;

endmodule

// File: doc/btu_arbiter.md
Name: btu_arbiter

Overview:
- Shares one btu_top instance between NUM_REQ requesters, such as per-core or per-warp issue ports.
- Arbitrates requests round-robin and forwards the winner's btu_input_t to the BTU.
- Records the winner's ID in an in-order tag FIFO and routes each btu_output_t back to the requester that issued it.
- Sits between the requester ports and btu_top; owns both BTU handshakes.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_OUTSTANDING, 2, tag FIFO depth: the maximum number of issued-but-unreturned operations (power of 2, >=1).
- ID_W, $clog2(NUM_REQ), requester ID width (derived localparam).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted.
- req_data  in  NUM_REQ x btu_input_t  per-requester operands.
- btu_valid_in  out  1  to BTU valid_in.
- btu_ready_in  in  1  from BTU ready_in.
- btu_data_in  out  btu_input_t  to BTU data_in.
- btu_valid_out  in  1  from BTU valid_out.
- btu_ready_out  out  1  to BTU ready_out.
- btu_data_out  in  btu_output_t  from BTU data_out.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_ready  in  NUM_REQ  per-requester response ready.
- rsp_data  out  btu_output_t  response payload, broadcast to all requesters.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy.
- proto_err  out  1  sticky error flag.

Behaviour:
- Reset values (async on rst_n low):
  - rr_ptr=0, FIFO empty, outstanding=0, lock cleared, proto_err=0.
  - All valid/ready outputs are 0.
- Arbitration FSM has two states, ARB and HOLD.
  - ARB:
    - grant = first i with req_valid[i], searching from rr_ptr upward with wrap.
    - btu_valid_in = |req_valid & !fifo_full.
    - btu_data_in = req_data[grant].
  - ARB -> HOLD when btu_valid_in & !btu_ready_in. The grant is registered as held_id.
  - HOLD:
    - grant = held_id.
    - btu_valid_in = 1 and btu_data_in = req_data[held_id], stable until accepted. The requester must hold req_valid.
    - If req_valid[held_id] drops in HOLD, set proto_err and return to ARB.
  - Issue handshake = btu_valid_in & btu_ready_in. On issue:
    - req_ready[grant]=1 in the same cycle (combinational from btu_ready_in).
    - Push grant into the FIFO.
    - rr_ptr <= grant+1 mod NUM_REQ.
    - State -> ARB.
- FIFO full blocks issue. fifo_full is evaluated on pre-pop occupancy, with no same-cycle bypass.
- Response path:
  - head = FIFO front.
  - rsp_valid[head] = btu_valid_out & !fifo_empty; all other rsp_valid bits are 0.
  - rsp_data = btu_data_out, passed through combinationally.
  - btu_ready_out = rsp_ready[head] when the FIFO is non-empty.
  - Pop on btu_valid_out & btu_ready_out.
- Push and pop in the same cycle are legal when the FIFO is non-full. Occupancy is unchanged; pointers advance with wrap.
- If btu_valid_out is asserted while the FIFO is empty:
  - Set proto_err.
  - Drive btu_ready_out=1 to drain.
  - Drive no rsp_valid.
- Latency:
  - Zero added cycles on the issue path and the response path; the arbiter is purely combinational in both paths apart from the tag FIFO.
  - With btu_top, request-accept to rsp_valid is 2 cycles.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 issues.
- proto_err clears only on reset.

Decomposition:
- btu_pkg gets btu_arb_state_t {ARB, HOLD}.
- btu_input_t and btu_output_t are reused from btu_pkg unchanged.
- One sub-module: btu_tag_fifo (parameterised DEPTH and WIDTH, flop-based, with full, empty and count outputs), instantiated with WIDTH=ID_W.
- The round-robin picker is an inline function.

Test Plan:
- Single request: req_valid[2]=1 with n=4, BTU idle -> req_ready[2] pulses that cycle; 2 cycles later rsp_valid=4'b0100 with num_rows=16; outstanding goes 1 then 0.
- Contention: all four req_valid held high, rsp_ready all 1 -> issue order 0,1,2,3,0; rsp_valid order matches.
- HOLD stability: BTU busy (ready_in=0) while req_valid[1] and req_valid[3] are high -> btu_data_in stays equal to req_data[1] until accept, even if req_valid[0] rises meanwhile.
- Response backpressure and full FIFO, with MAX_OUTSTANDING=1 and rsp_ready[0]=0 held 5 cycles:
  - btu_ready_out=0.
  - A second request from port 1 is not issued (btu_valid_in=0).
  - After rsp_ready[0]=1: pop and issue happen in consecutive cycles.
- Protocol errors:
  - Force btu_valid_out=1 with the FIFO empty -> proto_err=1, btu_ready_out=1, rsp_valid=0.
  - Drop req_valid while in HOLD -> proto_err=1.
- Reset mid-operation: assert rst_n=0 with 2 outstanding -> outstanding=0, rsp_valid=0, rr_ptr=0 immediately (asynchronous); the next request from port 3 is issued normally.
